// File: rtl/credential_entry.sv
// credential_entry: keypad entry of a 4-digit account number (<= 4095) and a PIN digit,
// handshaking with an authentication stage and enforcing retry lockout.
module credential_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_valid,
    input  logic        auth_ok,
    input  logic        logout,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic        cred_valid,
    output logic        session_active,
    output logic        entry_err,
    output logic        locked,
    output logic [1:0]  tries
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ACC, PIN, WAIT_RESULT, SESSION, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [13:0]   acc_q, acc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [11:0]   accn_q, accn_d;
    logic [3:0]    pin_q, pin_d;
    logic          pin_seen_q, pin_seen_d;
    logic [1:0]    tries_q, tries_d;
    logic          cred_q, cred_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] lock_q, lock_d;

    logic        is_digit, is_clr, is_ent, in_tmo, key_acc, tmo_evt, lock_done, fail_lock;
    logic [13:0] acc_next;

    assign is_digit  = key_valid && key_code <= 4'd9;
    assign is_clr    = key_valid && key_code == 4'd10;
    assign is_ent    = key_valid && key_code == 4'd11;
    assign in_tmo    = state_q == ACC || state_q == PIN || state_q == WAIT_RESULT;
    assign key_acc   = (state_q == ACC || state_q == PIN) && key_valid && key_code <= 4'd11;
    // a key or an auth result landing on the timeout cycle wins over the timeout
    assign tmo_evt   = in_tmo && timer_q == TW'(TIMEOUT_CYCLES - 1) && !key_acc
                       && !(state_q == WAIT_RESULT && auth_valid);
    assign lock_done = lock_q == LW'(LOCK_CYCLES - 1);
    assign fail_lock = int'(tries_q) + 1 >= MAX_TRIES;
    assign acc_next  = acc_q * 14'd10 + 14'(key_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            accn_q     <= '0;
            pin_q      <= '0;
            pin_seen_q <= 1'b0;
            tries_q    <= '0;
            cred_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            accn_q     <= accn_d;
            pin_q      <= pin_d;
            pin_seen_q <= pin_seen_d;
            tries_q    <= tries_d;
            cred_q     <= cred_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            lock_q     <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = is_digit ? ACC : IDLE;
            ACC:         if (is_clr || is_ent) state_d = IDLE;
                         else if (is_digit && cnt_q == 2'd3) state_d = acc_next <= 14'd4095 ? PIN : IDLE;
            PIN:         if (is_clr) state_d = IDLE;
                         else if (is_ent && pin_seen_q) state_d = WAIT_RESULT;
            WAIT_RESULT: if (auth_valid) state_d = auth_ok ? SESSION : (fail_lock ? LOCKED : IDLE);
            SESSION:     if (logout) state_d = IDLE;
            LOCKED:      if (lock_done) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (tmo_evt) state_d = IDLE;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        accn_d     = accn_q;
        pin_d      = pin_q;
        pin_seen_d = pin_seen_q;
        tries_d    = tries_q;
        cred_d     = 1'b0;
        err_d      = tmo_evt;
        timer_d    = (state_d != state_q || key_acc || !in_tmo) ? '0 : timer_q + 1'b1;
        lock_d     = (state_q == LOCKED && state_d == LOCKED) ? lock_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (is_digit) begin
                acc_d = 14'(key_code);
                cnt_d = 2'd1;
            end
            ACC: if (is_ent) err_d = 1'b1;
            else if (is_digit && cnt_q == 2'd3) begin
                err_d  = acc_next > 14'd4095;
                accn_d = acc_next[11:0];
                acc_d  = '0;
                cnt_d  = '0;
            end else if (is_digit) begin
                acc_d = acc_next;
                cnt_d = cnt_q + 2'd1;
            end
            PIN: if (is_digit) begin
                pin_d      = key_code;
                pin_seen_d = 1'b1;
            end else if (is_ent) begin
                cred_d = pin_seen_q;
                err_d  = !pin_seen_q;
            end
            WAIT_RESULT: if (auth_valid) tries_d = auth_ok ? 2'd0 : tries_q + 2'd1;
            LOCKED: if (lock_done) tries_d = 2'd0;
            default: ;
        endcase
        // credentials never survive a return to IDLE or entry into lockout
        if (state_d == IDLE || state_d == LOCKED) begin
            acc_d      = '0;
            cnt_d      = '0;
            accn_d     = '0;
            pin_d      = '0;
            pin_seen_d = 1'b0;
        end
    end

    assign acc_number     = accn_q;
    assign pin            = pin_q;
    assign cred_valid     = cred_q;
    assign entry_err      = err_q;
    assign session_active = state_q == SESSION;
    assign locked         = state_q == LOCKED;
    assign tries          = tries_q;
endmodule
